// File: rtl/id_ex_issue_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_issue_ctrl
//
// Moves decoded instructions from the ID stage into the ID/EX pipeline
// register under a valid/ready handshake. Bubbles are inserted when the
// instruction sitting in EX is a load whose destination is read by the ID
// instruction (load-use hazard). A branch/jump flush from EX kills the
// ID-stage instruction.
//
// Parameters
//   PC_W           width of the PC carried alongside each instruction
//   BUBBLE_CYCLES  bubbles inserted per load-use hazard (1..3)
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   id_valid       ID holds a decoded instruction (id_decode, id_pc)
//   id_ready       ID/EX accepts the ID instruction this cycle (combinational)
//   id_decode      72-bit decode bundle from the decoder
//   id_pc          PC of the ID instruction
//   ex_valid       ex_decode/ex_pc hold a live instruction
//   ex_ready       EX consumes the current ID/EX contents this cycle
//   ex_decode      registered decode bundle
//   ex_pc          registered PC
//   flush          EX resolved a taken branch/jump; kill the ID instruction
//   stall_count    saturating count of hazard bubbles written
//
// Decode bundle layout:
//   InstType[71:69] rs[68:64] rt[63:59] rd[58:54] imm[53:22] EXTop[21:16]
//   NPCop[15:13] ALUsrc[12] ALUop[11:7] DMWe[6] DMsign[5] DMwidth[4:3]
//   RFWe[2] RFWsrc[1:0]
// ---------------------------------------------------------------------------
module id_ex_issue_ctrl #(
    parameter int PC_W          = 32,
    parameter int BUBBLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [71:0]     id_decode,
    input  logic [PC_W-1:0] id_pc,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [71:0]     ex_decode,
    output logic [PC_W-1:0] ex_pc,
    input  logic            flush,
    output logic [15:0]     stall_count
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    // Bubbles still owed after the first one, loaded on hazard entry.
    localparam logic [1:0] BCNT_INIT = 2'(BUBBLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] bcnt_q, bcnt_d;

    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       hazard;
    logic       accept;
    logic       bubble_written;

    // A load is a register-file write sourced from data memory; rd=0 is
    // never a real destination, so it can never create a hazard.
    assign ex_rd      = ex_decode[58:54];
    assign ex_is_load = ex_valid & ex_decode[2] & (ex_decode[1:0] == 2'b01)
                        & (ex_rd != 5'd0);

    // rs and rt are both compared regardless of instruction type; a false
    // stall on an unused rt is cheaper than decoding operand usage here.
    assign hazard = id_valid & ex_is_load
                    & ((ex_rd == id_decode[68:64]) | (ex_rd == id_decode[63:59]));

    assign id_ready = (state_q == RUN) & ~hazard & ~flush & (~ex_valid | ex_ready);
    assign accept   = id_valid & id_ready;

    // Counted bubbles: the first one in RUN (hazard with EX draining) and
    // every BUBBLE-state cycle; a flush suppresses both.
    assign bubble_written = ~flush & (((state_q == RUN) & hazard & ex_ready)
                                      | (state_q == BUBBLE));

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        if (flush) begin
            state_d = RUN;
            bcnt_d  = 2'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard && ex_ready && (BUBBLE_CYCLES > 1)) begin
                        state_d = BUBBLE;
                        bcnt_d  = BCNT_INIT;
                    end
                end
                BUBBLE: begin
                    bcnt_d = bcnt_q - 2'd1;
                    if (bcnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    bcnt_d  = 2'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            bcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // NOTE: the payload is reset along with ex_valid so a reset mid-stream
    // leaves no stale instruction bits visible on ex_decode/ex_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_decode <= '0;
            ex_pc     <= '0;
        end else if (flush) begin
            // The EX instruction is older than the branch and survives if it
            // has not drained yet; otherwise the register empties.
            if (!ex_valid || ex_ready) begin
                ex_valid  <= 1'b0;
                ex_decode <= '0;
                ex_pc     <= '0;
            end
        end else if (accept) begin
            ex_valid  <= 1'b1;
            ex_decode <= id_decode;
            ex_pc     <= id_pc;
        end else if (ex_ready || !ex_valid) begin
            // Bubble: all-zero bundle clears RFWe and DMWe. PC is held.
            ex_valid  <= 1'b0;
            ex_decode <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (bubble_written && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_ex_issue_ctrl
//
// Two instances share one stimulus stream: BUBBLE_CYCLES=1 and =3. Each is
// compared every cycle against a reference model that tracks the ID/EX
// register contents and a count of bubbles still owed. A hand-computed vector
// table, directed backpressure and reset sequences, and a random run follow.
// ---------------------------------------------------------------------------
module tb_id_ex_issue_ctrl;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [71:0]     id_decode;
    logic [PC_W-1:0] id_pc;
    logic            ex_ready;
    logic            flush;

    logic            id_ready1, ex_valid1, id_ready3, ex_valid3;
    logic [71:0]     ex_decode1, ex_decode3;
    logic [PC_W-1:0] ex_pc1, ex_pc3;
    logic [15:0]     stall1, stall3;

    always #5 clk = ~clk;

    id_ex_issue_ctrl #(.PC_W(PC_W), .BUBBLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready1),
        .id_decode(id_decode), .id_pc(id_pc), .ex_valid(ex_valid1),
        .ex_ready(ex_ready), .ex_decode(ex_decode1), .ex_pc(ex_pc1),
        .flush(flush), .stall_count(stall1)
    );

    id_ex_issue_ctrl #(.PC_W(PC_W), .BUBBLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready3),
        .id_decode(id_decode), .id_pc(id_pc), .ex_valid(ex_valid3),
        .ex_ready(ex_ready), .ex_decode(ex_decode3), .ex_pc(ex_pc3),
        .flush(flush), .stall_count(stall3)
    );

    // Index 0 -> BUBBLE_CYCLES=1 instance, index 1 -> BUBBLE_CYCLES=3.
    logic            a_rdy[2];
    logic            a_ev[2];
    logic [71:0]     a_dec[2];
    logic [PC_W-1:0] a_pc[2];
    logic [15:0]     a_cnt[2];
    assign a_rdy[0] = id_ready1;  assign a_rdy[1] = id_ready3;
    assign a_ev[0]  = ex_valid1;  assign a_ev[1]  = ex_valid3;
    assign a_dec[0] = ex_decode1; assign a_dec[1] = ex_decode3;
    assign a_pc[0]  = ex_pc1;     assign a_pc[1]  = ex_pc3;
    assign a_cnt[0] = stall1;     assign a_cnt[1] = stall3;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              bc[2] = '{1, 3};
    bit              m_ev[2];
    logic [71:0]     m_dec[2];
    logic [PC_W-1:0] m_pc[2];
    int              m_left[2];   // bubbles still owed for the current hazard
    int              m_cnt[2];

    function automatic bit m_hazard(int k);
        logic [4:0] rd;
        bit         is_load;
        rd      = m_dec[k][58:54];
        is_load = m_ev[k] && m_dec[k][2] && (m_dec[k][1:0] == 2'b01) && (rd != 5'd0);
        return id_valid && is_load && (rd == id_decode[68:64] || rd == id_decode[63:59]);
    endfunction

    function automatic bit m_ready(int k);
        return (m_left[k] == 0) && !m_hazard(k) && !flush && (!m_ev[k] || ex_ready);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ev[k] = 1'b0; m_dec[k] = '0; m_pc[k] = '0; m_left[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            bit rdy, hz;
            rdy = m_ready(k);
            hz  = m_hazard(k);
            if (flush) begin
                if (!m_ev[k] || ex_ready) begin
                    m_ev[k] = 1'b0; m_dec[k] = '0; m_pc[k] = '0;
                end
                m_left[k] = 0;
            end else if (id_valid && rdy) begin
                m_ev[k] = 1'b1; m_dec[k] = id_decode; m_pc[k] = id_pc;
            end else if (ex_ready || !m_ev[k]) begin
                if (m_left[k] > 0) begin
                    m_left[k]--;
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                end else if (hz) begin
                    m_left[k] = bc[k] - 1;
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                end
                m_ev[k] = 1'b0; m_dec[k] = '0;
            end
        end
    endtask

    // Let combinational outputs settle, then compare both instances to model.
    task automatic settle_check();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bc%0d id_ready", bc[k]), 72'(a_rdy[k]), 72'(m_ready(k)));
            check($sformatf("bc%0d ex_valid", bc[k]), 72'(a_ev[k]), 72'(m_ev[k]));
            check($sformatf("bc%0d ex_decode", bc[k]), a_dec[k], m_dec[k]);
            if (m_ev[k]) check($sformatf("bc%0d ex_pc", bc[k]), 72'(a_pc[k]), 72'(m_pc[k]));
            check($sformatf("bc%0d stall_count", bc[k]), 72'(a_cnt[k]), 72'(16'(m_cnt[k])));
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        m_step();
        #1;
    endtask

    function automatic logic [71:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic we,
                                       input logic [1:0] src);
        logic [71:0] d;
        d        = '0;
        d[71:69] = 3'd1;
        d[68:64] = rs;
        d[63:59] = rt;
        d[58:54] = rd;
        d[53:22] = 32'hA5A5_0000 | 32'(rd);
        d[11:7]  = 5'd3;
        d[2]     = we;
        d[1:0]   = src;
        return d;
    endfunction

    typedef struct {
        bit          iv;
        logic [71:0] dec;
        bit          xr;
        bit          fl;
        bit          rdy1;
        bit          ev1;
        int          cnt1;
        bit          rdy3;
        bit          ev3;
        int          cnt3;
    } vec_t;

    initial begin
        vec_t        tbl[16];
        logic [71:0] ld5, ld7, ld0, a_rs5, a_rt7, a_r0, alu, dec_a, dec_b;

        ld5   = mk(5'd1, 5'd2, 5'd5, 1'b1, 2'b01);
        ld7   = mk(5'd1, 5'd2, 5'd7, 1'b1, 2'b01);
        ld0   = mk(5'd1, 5'd2, 5'd0, 1'b1, 2'b01);
        a_rs5 = mk(5'd5, 5'd0, 5'd6, 1'b1, 2'b00);
        a_rt7 = mk(5'd0, 5'd7, 5'd6, 1'b1, 2'b00);
        a_r0  = mk(5'd0, 5'd0, 5'd6, 1'b1, 2'b00);
        alu   = mk(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);

        // Inputs, then expected {id_ready, ex_valid, stall_count} for the
        // BUBBLE_CYCLES=1 and =3 instances, sampled before the edge.
        tbl[0]  = '{1, ld5,   1, 0,  1, 0, 0,  1, 0, 0};  // load rd=5 accepted
        tbl[1]  = '{1, a_rs5, 1, 0,  0, 1, 0,  0, 1, 0};  // rs hazard
        tbl[2]  = '{1, a_rs5, 1, 0,  1, 0, 1,  0, 0, 1};
        tbl[3]  = '{1, a_rs5, 1, 0,  1, 1, 1,  0, 0, 2};
        tbl[4]  = '{1, a_rs5, 1, 0,  1, 1, 1,  1, 0, 3};
        tbl[5]  = '{1, ld7,   1, 0,  1, 1, 1,  1, 1, 3};  // load rd=7 accepted
        tbl[6]  = '{1, a_rt7, 1, 0,  0, 1, 1,  0, 1, 3};  // rt hazard
        tbl[7]  = '{1, a_rt7, 1, 1,  0, 0, 2,  0, 0, 4};  // flush aborts bubbles
        tbl[8]  = '{1, a_rt7, 1, 0,  1, 0, 2,  1, 0, 4};
        tbl[9]  = '{1, ld0,   1, 0,  1, 1, 2,  1, 1, 4};  // load to r0
        tbl[10] = '{1, a_r0,  1, 0,  1, 1, 2,  1, 1, 4};  // r0 never hazards
        tbl[11] = '{1, alu,   0, 0,  0, 1, 2,  0, 1, 4};  // backpressure
        tbl[12] = '{1, alu,   0, 0,  0, 1, 2,  0, 1, 4};
        tbl[13] = '{1, alu,   1, 0,  1, 1, 2,  1, 1, 4};
        tbl[14] = '{0, alu,   1, 0,  1, 1, 2,  1, 1, 4};  // drain
        tbl[15] = '{0, alu,   1, 0,  1, 0, 2,  1, 0, 4};

        // ---------------- reset ----------------
        rst_n = 1'b0; id_valid = 1'b0; id_decode = '0; id_pc = '0;
        ex_ready = 1'b1; flush = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle_check();
        check("reset id_ready bc1", 72'(id_ready1), 72'(1'b1));
        check("reset stall bc3", 72'(stall3), 72'(16'd0));

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            id_valid  = tbl[i].iv;
            id_decode = tbl[i].dec;
            id_pc     = 32'h1000 + 32'(4 * i);
            ex_ready  = tbl[i].xr;
            flush     = tbl[i].fl;
            settle_check();
            check($sformatf("vec%0d bc1 id_ready", i), 72'(id_ready1), 72'(tbl[i].rdy1));
            check($sformatf("vec%0d bc1 ex_valid", i), 72'(ex_valid1), 72'(tbl[i].ev1));
            check($sformatf("vec%0d bc1 stall", i), 72'(stall1), 72'(16'(tbl[i].cnt1)));
            check($sformatf("vec%0d bc3 id_ready", i), 72'(id_ready3), 72'(tbl[i].rdy3));
            check($sformatf("vec%0d bc3 ex_valid", i), 72'(ex_valid3), 72'(tbl[i].ev3));
            check($sformatf("vec%0d bc3 stall", i), 72'(stall3), 72'(16'(tbl[i].cnt3)));
            clk_step();
        end

        // ---------------- backpressure hold ----------------
        dec_a = mk(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
        dec_b = mk(5'd3, 5'd4, 5'd9, 1'b1, 2'b00);
        id_valid = 1'b1; id_decode = dec_a; id_pc = 32'h200; ex_ready = 1'b1; flush = 1'b0;
        settle_check();
        clk_step();
        id_decode = dec_b; id_pc = 32'h204; ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle_check();
            check("bp hold decode bc1", ex_decode1, dec_a);
            check("bp hold pc bc3", 72'(ex_pc3), 72'(32'h200));
            check("bp id_ready bc3", 72'(id_ready3), 72'(1'b0));
            clk_step();
        end
        ex_ready = 1'b1;
        settle_check();
        check("bp resume id_ready bc1", 72'(id_ready1), 72'(1'b1));
        clk_step();
        settle_check();
        check("bp resume decode bc3", ex_decode3, dec_b);
        check("bp resume pc bc1", 72'(ex_pc1), 72'(32'h204));

        // ---------------- reset mid-stream ----------------
        id_decode = alu; id_pc = 32'h300;
        clk_step();
        settle_check();
        #2 rst_n = 1'b0;
        #1;
        check("midrst ex_valid bc1", 72'(ex_valid1), 72'(1'b0));
        check("midrst ex_decode bc1", ex_decode1, 72'(0));
        check("midrst stall bc1", 72'(stall1), 72'(16'd0));
        check("midrst ex_valid bc3", 72'(ex_valid3), 72'(1'b0));
        check("midrst ex_decode bc3", ex_decode3, 72'(0));
        check("midrst stall bc3", 72'(stall3), 72'(16'd0));
        m_reset();
        #1 rst_n = 1'b1;
        id_valid = 1'b0;
        settle_check();
        check("post-rst id_ready bc1", 72'(id_ready1), 72'(1'b1));
        check("post-rst id_ready bc3", 72'(id_ready3), 72'(1'b1));
        clk_step();

        // ---------------- random ----------------
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rs, rt, rd;
            logic       we;
            logic [1:0] src;
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            we  = ($urandom_range(0, 3) != 0);
            src = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
            id_valid  = ($urandom_range(0, 3) != 0);
            id_decode = mk(rs, rt, rd, we, src);
            id_decode[53:22] = $urandom;
            id_pc     = $urandom;
            ex_ready  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            settle_check();
            clk_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
